// File: rtl/maze_gen.sv
// maze_gen: depth-first perfect-maze carver over a W x H grid of cells.
// Walls are kept per cell as {wall_e, wall_s}. The north and west walls of a
// cell live in its upper and left neighbours, and the outer west and north
// border is implicit. Generation runs CLEAR (W*H cycles) followed by STEP
// (2*W*H-1 cycles), so the latency from start to done is always 3*W*H.
// Optional build macro: MAZE_GEN_STATS_EN adds the max_depth and dead_ends outputs.
module maze_gen #(
    parameter int          W    = 16,
    parameter int          H    = 8,
    parameter int          XW   = (W > 1) ? $clog2(W) : 1,
    parameter int          YW   = (H > 1) ? $clog2(H) : 1,
    parameter logic [15:0] SEED = 16'hACE1,
    localparam int         N    = W * H,
    localparam int         PW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   seed,
    output logic          busy,
    output logic          done,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic [1:0]    rd_cell
`ifdef MAZE_GEN_STATS_EN
    ,
    output logic [PW-1:0] max_depth,
    output logic [PW-1:0] dead_ends
`endif
);

    localparam int            IW     = (N > 1) ? $clog2(N) : 1;
    localparam int            DEPTH  = 1 << IW;
    localparam logic [IW-1:0] ORIGIN = '0;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STEP} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic          visited [DEPTH];
    logic          wall_e  [DEPTH];
    logic          wall_s  [DEPTH];
    logic [XW-1:0] stack_x [DEPTH];
    logic [YW-1:0] stack_y [DEPTH];
    logic [PW-1:0] sp;
    logic [IW-1:0] clr_idx;
    logic [XW-1:0] cur_x, nbr_x;
    logic [YW-1:0] cur_y, nbr_y;
    logic [IW-1:0] cur_idx, e_idx, s_idx, w_idx, n_idx, nbr_idx, top_idx, rd_idx;
    logic [3:0]    mask;
    logic [1:0]    pick, dir;
    logic          found;
    logic          accept, do_push, do_pop, finish;

    // Flat cell index is y*W + x. Neighbour indices may wrap when out of
    // bounds; the bounds terms in the mask keep such values from being used.
    assign cur_idx = IW'(int'(cur_y) * W + int'(cur_x));
    assign e_idx   = IW'(int'(cur_idx) + 1);
    assign s_idx   = IW'(int'(cur_idx) + W);
    assign w_idx   = IW'(int'(cur_idx) - 1);
    assign n_idx   = IW'(int'(cur_idx) - W);
    assign top_idx = IW'(sp - PW'(1));
    assign rd_idx  = IW'(int'(rd_y) * W + int'(rd_x));
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign accept  = (state == S_IDLE) && start;
    assign do_push = (state == S_STEP) && (mask != 4'b0000);
    assign do_pop  = (state == S_STEP) && (mask == 4'b0000) && (sp != '0);
    assign finish  = (state == S_STEP) && (mask == 4'b0000) && (sp == '0);

    // Open neighbours of the current cell: E(0), S(1), W(2), N(3)
    always_comb begin
        mask    = 4'b0000;
        mask[0] = (int'(cur_x) < W - 1) && !visited[e_idx];
        mask[1] = (int'(cur_y) < H - 1) && !visited[s_idx];
        mask[2] = (cur_x != '0) && !visited[w_idx];
        mask[3] = (cur_y != '0) && !visited[n_idx];
    end

    // First open direction found rotating upward from lfsr[1:0]
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        dir   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            dir = lfsr[1:0] + 2'(k);
            if (!found && mask[dir]) begin
                pick  = dir;
                found = 1'b1;
            end
        end
    end

    // Coordinates and index of the chosen neighbour
    always_comb begin
        nbr_x   = cur_x;
        nbr_y   = cur_y;
        nbr_idx = e_idx;
        case (pick)
            2'd0: begin nbr_x = cur_x + XW'(1); nbr_idx = e_idx; end
            2'd1: begin nbr_y = cur_y + YW'(1); nbr_idx = s_idx; end
            2'd2: begin nbr_x = cur_x - XW'(1); nbr_idx = w_idx; end
            default: begin nbr_y = cur_y - YW'(1); nbr_idx = n_idx; end
        endcase
    end

    // Generation FSM: handshake, LFSR, clear sweep, carve/backtrack, cell storage
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            lfsr    <= SEED;
            sp      <= '0;
            clr_idx <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
        end else begin
            if (busy)
                lfsr <= {lfsr[14:0], lfsr_fb};
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr    <= (seed == 16'h0000) ? SEED : seed;
                        state   <= S_CLEAR;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        clr_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    visited[clr_idx] <= 1'b0;
                    wall_e[clr_idx]  <= 1'b1;
                    wall_s[clr_idx]  <= 1'b1;
                    if (int'(clr_idx) == N - 1) begin
                        // Written after the clear above so it wins when N == 1
                        visited[ORIGIN] <= 1'b1;
                        cur_x <= '0;
                        cur_y <= '0;
                        sp    <= '0;
                        state <= S_STEP;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                S_STEP: begin
                    if (do_push) begin
                        case (pick)
                            2'd0:    wall_e[cur_idx] <= 1'b0;
                            2'd1:    wall_s[cur_idx] <= 1'b0;
                            2'd2:    wall_e[w_idx]   <= 1'b0;
                            default: wall_s[n_idx]   <= 1'b0;
                        endcase
                        visited[nbr_idx]  <= 1'b1;
                        stack_x[IW'(sp)]  <= cur_x;
                        stack_y[IW'(sp)]  <= cur_y;
                        sp    <= sp + PW'(1);
                        cur_x <= nbr_x;
                        cur_y <= nbr_y;
                    end else if (do_pop) begin
                        cur_x <= stack_x[top_idx];
                        cur_y <= stack_y[top_idx];
                        sp    <= sp - PW'(1);
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered read port; addresses outside the grid read as fully walled
    always_ff @(posedge clk) begin
        if (reset)
            rd_cell <= 2'b00;
        else if (int'(rd_x) >= W || int'(rd_y) >= H)
            rd_cell <= 2'b11;
        else
            rd_cell <= {wall_e[rd_idx], wall_s[rd_idx]};
    end

`ifdef MAZE_GEN_STATS_EN
    logic last_push;

    // Run statistics: peak stack depth and cells with a single opening
    always_ff @(posedge clk) begin
        if (reset) begin
            max_depth <= '0;
            dead_ends <= '0;
            last_push <= 1'b0;
        end else if (accept) begin
            max_depth <= '0;
            dead_ends <= '0;
            last_push <= 1'b0;
        end else begin
            if (do_push) begin
                last_push <= 1'b1;
                if (sp + PW'(1) > max_depth)
                    max_depth <= sp + PW'(1);
            end
            if (do_pop) begin
                last_push <= 1'b0;
                if (last_push)
                    dead_ends <= dead_ends + PW'(1);
            end
            // The root is a leaf only if exactly one of its own walls is open
            if (finish && (wall_e[ORIGIN] ^ wall_s[ORIGIN]))
                dead_ends <= dead_ends + PW'(1);
        end
    end
`endif

endmodule

// File: doc/maze_gen.md
# maze_gen

Parametrised depth-first maze generator that carves a perfect maze (a spanning tree) over a W×H grid of cells, using an explicit coordinate stack and an internal LFSR.
- Cell wall state is held internally and exposed through a registered read port, so the VGA/display and player-logic blocks can scan the maze after generation.
- Generalises the fixed 128×64 carver: configurable grid size, seeded randomness, a start/busy/done handshake and a guaranteed cycle count.

## Interface
- W, 16, grid width in cells (≥1)
- H, 8, grid height in cells (≥1)
- XW, $clog2(W) (min 1), x coordinate width
- YW, $clog2(H) (min 1), y coordinate width
- SEED, 16'hACE1, LFSR reset value and substitute for a zero seed
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin generation; sampled only while idle
- seed  in  16  LFSR seed, sampled with an accepted start
- busy  out  1  generation in progress
- done  out  1  maze valid; level, held until next accepted start or reset
- rd_x  in  XW  read-port cell x
- rd_y  in  YW  read-port cell y
- rd_cell  out  2  {wall_e, wall_s} of cell (rd_x, rd_y), 1-cycle latency

## Operation
- Storage: per cell visited bit plus wall_e and wall_s (1 = wall present). The north wall of a cell is wall_s of the cell above; its west wall is wall_e of the cell to the left. The outer west and north border is implicit.
- Stack: W*H entries of {x,y} and a pointer of width $clog2(W*H+1).
- FSM IDLE: start=1 accepted, seed latched (seed==0 → SEED) → CLEAR.
- FSM CLEAR: one cell per cycle in raster order sets visited=0, wall_e=1, wall_s=1. After the last cell, (0,0) is marked visited, cur=(0,0), stack empty → STEP.
- FSM STEP, one action per cycle:
  - Compute a mask of in-bounds, unvisited neighbours in order E(0), S(1), W(2), N(3).
  - Mask ≠ 0: starting at index lfsr[1:0], rotate upward mod 4 and take the first set bit. Clear the shared wall, mark the neighbour visited, push cur, cur = neighbour.
  - Mask == 0, stack non-empty: pop into cur.
  - Mask == 0, stack empty: → DONE.
- FSM DONE: busy=0, done=1. Falls through to IDLE behaviour, so a new start is accepted.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle while busy and holds otherwise.
- Read port: rd_cell registered from the addressed cell every cycle regardless of state. Contents are meaningful only while done=1.
- Out-of-range rd_x/rd_y (non-power-of-2 W/H): rd_cell=2'b11.

## Timing
- Reset: busy=0, done=0, rd_cell=0, FSM=IDLE, LFSR=SEED, stack pointer=0.
- start accepted at edge T:
  - busy=1 from T+1.
  - CLEAR takes W*H cycles.
  - STEP takes exactly 2*W*H−1 cycles: W*H−1 pushes, W*H−1 pops, and 1 final empty check.
  - done=1 and busy=0 at T+3*W*H. Latency is fixed and seed-independent.
- start while busy: ignored, with no effect on seed or LFSR.
- start while done=1: accepted. done drops at T+1 and the maze is invalid until the next done.
- Reset mid-generation: returns to IDLE next cycle and done=0. Stored cells are undefined until the next done.
- Stack never overflows: depth ≤ W*H−1 by construction. Pop on empty cannot occur.
- W=1,H=1: CLEAR 1 cycle, STEP 1 cycle, done at T+3. The single cell reads 2'b11.

## Configuration
- MAZE_GEN_STATS_EN defined adds two outputs:
  - max_depth, width $clog2(W*H+1): peak stack pointer of the last run. Cleared on accepted start and on reset.
  - dead_ends, width $clog2(W*H+1): count of cells with exactly one opening. Accumulated during STEP as the number of pops taken directly after a push, plus 1 if cell (0,0) has a single opening. Valid with done.
- Not defined: both outputs and their counters are absent. All other behaviour and timing are identical.

## Test plan
- Reset then idle 10 cycles → busy=0, done=0, rd_cell=0. start pulse with W=4,H=4, seed=16'h1234 → busy at T+1, done exactly at T+48.
- After done (4×4): scan all 16 cells with rd_x/rd_y → rd_cell valid one cycle after address. Last column wall_e=1, last row wall_s=1. Exactly 9 of 24 interior walls remain (15 passages). BFS from (0,0) reaches all 16 cells with no cycle.
- Repeat with the same seed → identical rd_cell image. seed=16'h0000 → image identical to seed=SEED. seed=16'h5678 → image differs.
- start held high through the whole run → no restart until done. The next cycle's start is accepted and done drops at T+1.
- reset asserted at T+20 mid-run → busy=0, done=0 next cycle. A fresh start completes in 3*W*H cycles.
- W=1,H=1 → done at T+3, rd_cell(0,0)=2'b11. With MAZE_GEN_STATS_EN on 4×4: max_depth ≤ 15 and dead_ends ≥ 2.
